// File: rtl/decode_issue_stage.sv
// decode_issue_stage: instruction decode, register file read, scoreboard and issue.
// Optional macro DECODE_WB_BYPASS_EN forwards writeback data into the issue cycle.
module decode_issue_stage #(
    parameter int N     = 32,
    parameter int C     = 7,
    parameter int S     = 5,
    parameter int IMM_W = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         instr_valid,
    input  logic [N-1:0] instr,
    output logic         instr_ready,
    input  logic         wb_en,
    input  logic [S-1:0] wb_addr,
    input  logic [N-1:0] wb_data,
    output logic         enable_ex,
    output logic [N-1:0] src1,
    output logic [N-1:0] src2,
    output logic [N-1:0] imm,
    output logic [C-1:0] control_in,
    output logic [S-1:0] rd_out,
    output logic         stall
);

    localparam int R = 1 << S;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    state_t         state;
    logic [N-1:0]   rf [R];
    logic [R-1:0]   pending;
    logic [R-1:0]   pend_eff;
    logic [R-1:0]   wb_hit;
    logic [R-1:0]   set_hit;

    logic [C-1:0]   ctrl;
    logic [S-1:0]   rd;
    logic [S-1:0]   rs1;
    logic [S-1:0]   rs2;
    logic [N-1:0]   imm_ext;
    logic [2:0]     cls;
    logic           uses_rs2;
    logic           writes_rd;
    logic           hazard;
    logic           xfer;
    logic [N-1:0]   rd1;
    logic [N-1:0]   rd2;

    assign ctrl    = instr[31:25];
    assign rd      = instr[24:20];
    assign rs1     = instr[19:15];
    assign rs2     = instr[14:10];
    assign imm_ext = {{(N-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign cls     = ctrl[6:4];

    // Instruction class decides which operands matter to the scoreboard.
    always_comb begin
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        unique case (1'b1)
            (cls == 3'b000): begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            (cls == 3'b001), (cls == 3'b010): writes_rd = 1'b1;
            (cls == 3'b011), (cls == 3'b100): uses_rs2  = 1'b1;
            default: ;
        endcase
    end

    assign wb_hit  = wb_en ? ({{(R-1){1'b0}}, 1'b1} << wb_addr) : '0;
    assign set_hit = (xfer && writes_rd && rd != '0)
                   ? ({{(R-1){1'b0}}, 1'b1} << rd) : '0;

`ifdef DECODE_WB_BYPASS_EN
    assign pend_eff = pending & ~wb_hit;
`else
    assign pend_eff = pending;
`endif

    assign hazard = pend_eff[rs1]
                  | (uses_rs2 & pend_eff[rs2])
                  | (writes_rd & pend_eff[rd]);

    assign instr_ready = ~reset & (state != IDLE) & ~hazard;
    assign xfer        = instr_valid & instr_ready;

    // Operand read: r0 is hardwired zero, optional same-cycle forwarding.
    always_comb begin
        rd1 = (rs1 == '0) ? '0 : rf[rs1];
        rd2 = (rs2 == '0) ? '0 : rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == rs1 && rs1 != '0) rd1 = wb_data;
        if (wb_en && wb_addr == rs2 && rs2 != '0) rd2 = wb_data;
`endif
    end

    // Control FSM; stall is registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            stall <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                    stall <= 1'b0;
                end
                RUN: begin
                    if (instr_valid && hazard) begin
                        state <= STALL;
                        stall <= 1'b1;
                    end
                end
                STALL: begin
                    if (!instr_valid || !hazard) begin
                        state <= RUN;
                        stall <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    // Register file write port; a writeback during reset is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < R; i++) rf[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: writeback clears, issue sets, set wins on collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_hit) | set_hit;
        end
    end

    // Issue registers: pulse enable_ex, hold operands until next issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_ex  <= 1'b0;
            src1       <= '0;
            src2       <= '0;
            imm        <= '0;
            control_in <= '0;
            rd_out     <= '0;
        end else begin
            enable_ex <= xfer;
            if (xfer) begin
                src1       <= rd1;
                src2       <= rd2;
                imm        <= imm_ext;
                control_in <= ctrl;
                rd_out     <= rd;
            end
        end
    end

endmodule
